// File: rtl/sift_pkg.sv
// Shared SIFT pipeline widths and the DoG subtraction helper.
// Pure declarations: no latency, no flow control.
package sift_pkg;
   localparam int PIX_W   = 8;
   localparam int DOG_W   = 9;
   localparam int COORD_W = 10;

   // Zero-extending both operands keeps the full -255..+255 range in DOG_W bits.
   function automatic logic signed [DOG_W-1:0] dog_diff(input logic [PIX_W-1:0] a,
                                                        input logic [PIX_W-1:0] b);
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction
endpackage

// File: rtl/dog_line_buffer.sv
// One-line delay of DoG samples: dout is the sample written DEPTH enabled cycles ago.
// Advances only when en is high; contents are never cleared.
module dog_line_buffer #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    ptr;

   // Read-before-write at the same slot gives exactly one line of delay.
   assign dout = mem[ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         mem[ptr] <= din;
      end
   end
endmodule

// File: rtl/dog_extrema.sv
// 3x3 DoG extremum detector; result for centre (x,y) appears 1 cycle after pixel (x+1,y+1).
// No backpressure: all state freezes while In_Valid is low.
module dog_extrema
   import sift_pkg::*;
#(
   parameter int LINE_WIDTH   = 640,
   parameter int FRAME_HEIGHT = 480,
   parameter int THRESH       = 8
) (
   input  logic                    Clock,
   input  logic                    Rst,
   input  logic                    In_Valid,
   input  logic                    Sof,
   input  logic [PIX_W-1:0]        Blur_A,
   input  logic [PIX_W-1:0]        Blur_B,
   output logic                    Out_Valid,
   output logic signed [DOG_W-1:0] DoG_Out,
   output logic                    Keypoint,
   output logic                    Is_Max,
   output logic [COORD_W-1:0]      X,
   output logic [COORD_W-1:0]      Y
);
   localparam logic signed [DOG_W:0] THR = (DOG_W + 1)'(THRESH);

   logic [COORD_W-1:0]      col, row, cur_col, cur_row;
   logic                    restart, win_ok;
   logic signed [DOG_W-1:0] dog, row1_dat, row2_dat;
   logic signed [DOG_W-1:0] top1, top2, mid1, mid2, bot1, bot2;
   logic signed [DOG_W-1:0] nb [8];
   logic signed [DOG_W:0]   centre_x;
   logic                    is_gt, is_lt, above_thr, below_thr;

   assign dog     = dog_diff(Blur_A, Blur_B);
   assign restart = In_Valid && Sof;
   assign cur_col = restart ? '0 : col;
   assign cur_row = restart ? '0 : row;
   // Rows 0-1 never qualify, which also hides stale line-buffer contents after a restart.
   assign win_ok  = In_Valid && (cur_col >= COORD_W'(2)) && (cur_row >= COORD_W'(2));

   always_ff @(posedge Clock) begin
      if (Rst) begin
         col <= '0;
         row <= '0;
      end else if (In_Valid) begin
         if (cur_col == COORD_W'(LINE_WIDTH - 1)) begin
            col <= '0;
            row <= (cur_row == COORD_W'(FRAME_HEIGHT - 1)) ? '0 : cur_row + COORD_W'(1);
         end else begin
            col <= cur_col + COORD_W'(1);
            row <= cur_row;
         end
      end
   end

   dog_line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(DOG_W)) u_lb1 (
      .clk  (Clock),
      .rst  (Rst),
      .en   (In_Valid),
      .din  (dog),
      .dout (row1_dat)
   );

   dog_line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(DOG_W)) u_lb2 (
      .clk  (Clock),
      .rst  (Rst),
      .en   (In_Valid),
      .din  (row1_dat),
      .dout (row2_dat)
   );

   // Column history per window row; the live column comes straight from dog/row1/row2.
   always_ff @(posedge Clock) begin
      if (In_Valid) begin
         top1 <= row2_dat;
         top2 <= top1;
         mid1 <= row1_dat;
         mid2 <= mid1;
         bot1 <= dog;
         bot2 <= bot1;
      end
   end

   always_comb begin
      nb[0] = top2;
      nb[1] = top1;
      nb[2] = row2_dat;
      nb[3] = mid2;
      nb[4] = row1_dat;
      nb[5] = bot2;
      nb[6] = bot1;
      nb[7] = dog;
      is_gt = 1'b1;
      is_lt = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (!(mid1 > nb[i])) is_gt = 1'b0;
         if (!(mid1 < nb[i])) is_lt = 1'b0;
      end
   end

   assign centre_x  = {mid1[DOG_W-1], mid1};
   assign above_thr = centre_x > THR;
   assign below_thr = centre_x < -THR;

   always_ff @(posedge Clock) begin
      if (Rst) begin
         Out_Valid <= 1'b0;
         Keypoint  <= 1'b0;
         Is_Max    <= 1'b0;
         DoG_Out   <= '0;
         X         <= '0;
         Y         <= '0;
      end else begin
         Out_Valid <= win_ok;
         Keypoint  <= win_ok && ((is_gt && above_thr) || (is_lt && below_thr));
         Is_Max    <= win_ok && is_gt && above_thr;
         if (win_ok) begin
            DoG_Out <= mid1;
            X       <= cur_col - COORD_W'(1);
            Y       <= cur_row - COORD_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_dog_extrema.sv
// Directed bench for dog_extrema on an 8x8 frame with THRESH=8.
module tb_dog_extrema;
   localparam int LW = 8;
   localparam int FH = 8;
   localparam int TH = 8;

   typedef struct packed {
      logic [8:0] dog;
      logic       kp;
      logic       mx;
      logic [9:0] x;
      logic [9:0] y;
   } rec_t;

   logic       Clock = 1'b0;
   logic       Rst, In_Valid, Sof;
   logic [7:0] Blur_A, Blur_B;
   logic       Out_Valid, Keypoint, Is_Max;
   logic [8:0] DoG_Out;
   logic [9:0] X, Y;

   rec_t       q[$];
   rec_t       ref_q[$];
   rec_t       mon_r;
   logic [7:0] fa[64];
   logic [7:0] fb[64];
   int         n_pass  = 0;
   int         n_total = 0;

   always #5 Clock = ~Clock;

   dog_extrema #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .THRESH(TH)) dut (
      .Clock    (Clock),
      .Rst      (Rst),
      .In_Valid (In_Valid),
      .Sof      (Sof),
      .Blur_A   (Blur_A),
      .Blur_B   (Blur_B),
      .Out_Valid(Out_Valid),
      .DoG_Out  (DoG_Out),
      .Keypoint (Keypoint),
      .Is_Max   (Is_Max),
      .X        (X),
      .Y        (Y)
   );

   always @(negedge Clock) begin
      if (Out_Valid === 1'b1) begin
         mon_r.dog = DoG_Out;
         mon_r.kp  = Keypoint;
         mon_r.mx  = Is_Max;
         mon_r.x   = X;
         mon_r.y   = Y;
         q.push_back(mon_r);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t required < 200000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge Clock);
         In_Valid = 1'b0;
         Sof      = 1'b1;
         Blur_A   = 8'($urandom);
         Blur_B   = 8'($urandom);
      end
   endtask

   task automatic pix(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic do_chk, input logic exp_ov);
      @(negedge Clock);
      In_Valid = 1'b1;
      Sof      = s;
      Blur_A   = a;
      Blur_B   = b;
      @(posedge Clock);
      #1;
      if (do_chk) chk("ov_latency", 32'(Out_Valid), 32'(exp_ov));
   endtask

   task automatic send_frame(input logic first_sof, input logic gaps, input int stop);
      for (int i = 0; i < stop; i++) begin
         if (gaps && ($urandom_range(0, 1) == 1)) idle(1);
         pix(fa[i], fb[i], first_sof && (i == 0), !gaps, ((i % LW) >= 2) && ((i / LW) >= 2));
      end
      idle(3);
   endtask

   task automatic fill(input logic [7:0] a, input logic [7:0] b);
      for (int i = 0; i < 64; i++) begin
         fa[i] = a;
         fb[i] = b;
      end
   endtask

   task automatic analyze(input string tag, input int exp_kp, input rec_t exp_rec);
      int   nkp;
      rec_t last;
      nkp  = 0;
      last = '0;
      foreach (q[i]) begin
         if (q[i].kp) begin
            nkp++;
            last = q[i];
         end
      end
      chk({tag, "_count"}, 32'(q.size()), 32'd36);
      chk({tag, "_kp_count"}, 32'(nkp), 32'(exp_kp));
      if (exp_kp > 0) chk({tag, "_kp_rec"}, 32'(last), 32'(exp_rec));
   endtask

   task automatic match_ref(input string tag);
      chk({tag, "_count"}, 32'(q.size()), 32'(ref_q.size()));
      for (int i = 0; i < q.size() && i < ref_q.size(); i++)
         chk({tag, "_rec"}, 32'(q[i]), 32'(ref_q[i]));
   endtask

   initial begin
      In_Valid = 1'b0;
      Sof      = 1'b0;
      Blur_A   = '0;
      Blur_B   = '0;
      Rst      = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_out_valid", 32'(Out_Valid), 32'd0);
      chk("rst_keypoint", 32'(Keypoint), 32'd0);
      chk("rst_is_max", 32'(Is_Max), 32'd0);
      chk("rst_dog_out", 32'(DoG_Out), 32'd0);
      chk("rst_x", 32'(X), 32'd0);
      chk("rst_y", 32'(Y), 32'd0);
      @(negedge Clock);
      Rst = 1'b0;
      q.delete();

      // Single bright peak; first pixel after reset has no Sof.
      fill(8'd20, 8'd0);
      fa[3*8+3] = 8'd60;
      send_frame(1'b0, 1'b0, 64);
      analyze("max_peak", 1, '{9'd60, 1'b1, 1'b1, 10'd3, 10'd3});
      for (int i = 0; i < q.size(); i++)
         chk("max_peak_coord", 32'({q[i].x, q[i].y}), 32'({10'(1 + i % 6), 10'(1 + i / 6)}));
      ref_q = q;
      q.delete();

      // Single deep minimum: DoG -100 among -10.
      fill(8'd0, 8'd10);
      fb[2*8+4] = 8'd100;
      send_frame(1'b1, 1'b0, 64);
      analyze("min_pit", 1, '{9'h19C, 1'b1, 1'b0, 10'd4, 10'd2});
      q.delete();

      // +8 at (3,3) sits on the threshold; +9 at (5,5) clears it.
      fill(8'd0, 8'd0);
      fa[3*8+3] = 8'd8;
      fa[5*8+5] = 8'd9;
      send_frame(1'b1, 1'b0, 64);
      analyze("pos_thresh", 1, '{9'd9, 1'b1, 1'b1, 10'd5, 10'd5});
      q.delete();

      // -8 at (2,2) sits on the threshold; -9 at (5,5) clears it.
      fill(8'd0, 8'd0);
      fb[2*8+2] = 8'd8;
      fb[5*8+5] = 8'd9;
      send_frame(1'b1, 1'b0, 64);
      analyze("neg_thresh", 1, '{9'h1F7, 1'b1, 1'b0, 10'd5, 10'd5});
      q.delete();

      // Two adjacent equal peaks: ties never qualify.
      fill(8'd20, 8'd0);
      fa[3*8+3] = 8'd60;
      fa[3*8+4] = 8'd60;
      send_frame(1'b1, 1'b0, 64);
      analyze("tie", 0, '0);
      q.delete();

      // Peak frame again with random gaps, Sof toggling while idle.
      fill(8'd20, 8'd0);
      fa[3*8+3] = 8'd60;
      send_frame(1'b1, 1'b1, 64);
      match_ref("gaps");
      q.delete();

      // Sof at stream position (5,4) restarts the frame.
      send_frame(1'b1, 1'b0, 37);
      q.delete();
      send_frame(1'b1, 1'b0, 64);
      analyze("sof_restart", 1, '{9'd60, 1'b1, 1'b1, 10'd3, 10'd3});
      if (q.size() > 0) chk("sof_restart_first", 32'({q[0].x, q[0].y}), 32'({10'd1, 10'd1}));
      q.delete();

      // Reset mid-frame discards the partial frame; next pixel is (0,0) without Sof.
      send_frame(1'b1, 1'b0, 20);
      @(negedge Clock);
      Rst      = 1'b1;
      In_Valid = 1'b1;
      @(negedge Clock);
      Rst      = 1'b0;
      In_Valid = 1'b0;
      q.delete();
      send_frame(1'b0, 1'b0, 64);
      match_ref("mid_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dog_extrema.md
DOG_EXTREMA -- requirements
Module: dog_extrema

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 640, pixels per line (min 3).
REQ-002 SHALL have parameter FRAME_HEIGHT, default 480, lines per frame (min 3).
REQ-003 SHALL have parameter THRESH, default 8, unsigned contrast threshold on |DoG|.
REQ-004 SHALL have port Clock  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port In_Valid  input  1  Blur_A/Blur_B/Sof valid this cycle.
REQ-007 SHALL have port Sof  input  1  marks the current pixel as (0,0) of a new frame.
REQ-008 SHALL have port Blur_A  input  8  Gaussian output, finer scale.
REQ-009 SHALL have port Blur_B  input  8  Gaussian output, next coarser scale, same pixel.
REQ-010 SHALL have port Out_Valid  output  1  result fields valid this cycle.
REQ-011 SHALL have port DoG_Out  output  9  signed DoG of window centre.
REQ-012 SHALL have port Keypoint  output  1  centre is a qualified extremum.
REQ-013 SHALL have port Is_Max  output  1  1 = maximum, 0 = minimum; meaningful only with Keypoint.
REQ-014 SHALL have ports X, Y  output  10 each  centre pixel coordinates.

Function
REQ-015 SHALL compute per accepted pixel DoG = Blur_A - Blur_B as 9-bit two's complement (range -255..+255, no saturation needed).
REQ-016 SHALL keep column counter col and row counter row of the current accepted pixel; col wraps LINE_WIDTH-1 -> 0 with row+1; at (LINE_WIDTH-1, FRAME_HEIGHT-1) both wrap to 0.
REQ-017 SHALL, when In_Valid and Sof are both high, treat that pixel as (0,0) regardless of counter state; Sof with In_Valid low is ignored.
REQ-018 SHALL store the DoG values of the two previous lines in two line buffers of LINE_WIDTH x 9 bits, forming a 3x3 window whose bottom-right element is the current pixel.
REQ-019 SHALL hold all state when In_Valid is low (no bubbles inserted into the window).
REQ-020 SHALL assert Out_Valid exactly one cycle after an accepted pixel with col >= 2 and row >= 2, else deassert; X = col-1, Y = row-1 of that pixel.
REQ-021 SHALL set Keypoint=1, Is_Max=1 when centre > all 8 neighbours strictly and centre > +THRESH.
REQ-022 SHALL set Keypoint=1, Is_Max=0 when centre < all 8 neighbours strictly and centre < -THRESH.
REQ-023 SHALL treat any tie with a neighbour as non-extremum; Keypoint=0 otherwise.
REQ-024 SHALL never produce output for border pixels (x=0, x=LINE_WIDTH-1, y=0, y=FRAME_HEIGHT-1).
REQ-025 SHALL use only previous-line data from the same frame: after Sof, rows 0-1 produce no output even if line buffers hold stale data.
REQ-026 SHALL have total latency of 1 cycle from accepting pixel (x+1,y+1) to the result for centre (x,y).

Reset
REQ-027 SHALL on Rst drive Out_Valid, Keypoint, Is_Max to 0, DoG_Out, X, Y to 0, col and row to 0.
REQ-028 SHALL not require line-buffer contents to be cleared; REQ-025 masks them.
REQ-029 SHALL, on Rst mid-frame, discard the partial frame; the next accepted pixel is (0,0).

Structure
REQ-030 SHALL take PIX_W=8, DOG_W=9, COORD_W=10 from shared package sift_pkg.
REQ-031 SHALL implement each line buffer as sub-module dog_line_buffer (parameterised depth and width, enable-gated, 1-line delay).
REQ-032 SHALL keep comparison tree and threshold check in a single registered stage.

Verification
REQ-033 SHALL verify: Rst held 2 cycles -> all outputs 0; first valid pixel after is counted as (0,0).
REQ-034 SHALL verify: 8x8 frame (LINE_WIDTH=FRAME_HEIGHT=8), Blur_B=0, Blur_A=20 everywhere except 60 at (3,3) -> exactly one Keypoint at X=3,Y=3, Is_Max=1, DoG_Out=60; 36 Out_Valid pulses total.
REQ-035 SHALL verify: same frame, Blur_A=0, Blur_B=100 at (4,2), 10 elsewhere -> Keypoint at (4,2), Is_Max=0, DoG_Out=-100.
REQ-036 SHALL verify: centre DoG=+8 over neighbours 0 (THRESH=8) -> Keypoint=0; centre 60 with one neighbour 60 -> Keypoint=0.
REQ-037 SHALL verify: random In_Valid gaps (50% duty) on the REQ-034 frame -> identical result sequence to gap-free run.
REQ-038 SHALL verify: Sof asserted at pixel (5,4) mid-frame -> counters restart, no Out_Valid until new row 2, col 2.
